// File: rtl/timesync_pkg.sv
// timesync_pkg: shared state codes, requester indices and start-pulse decode for the phase sequencer
package timesync_pkg;
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CAPTURE = 4'd1,
    S_CALC_P  = 4'd2,
    S_CALC_R  = 4'd3,
    S_CALC_M  = 4'd4,
    S_DETECT  = 4'd5,
    S_EXTRACT = 4'd6,
    S_READY   = 4'd7,
    S_HALT    = 4'd8
  } state_t;
  localparam int NREQ = 4;
  localparam logic [1:0] REQ_CAP = 2'd0;
  localparam logic [1:0] REQ_P   = 2'd1;
  localparam logic [1:0] REQ_R   = 2'd2;
  localparam logic [1:0] REQ_EXT = 2'd3;
  // bit order: {ext, det, m, r, p}
  function automatic logic [4:0] start_mask(state_t s);
    return s == S_CALC_P  ? 5'b00001 :
           s == S_CALC_R  ? 5'b00010 :
           s == S_CALC_M  ? 5'b00100 :
           s == S_DETECT  ? 5'b01000 :
           s == S_EXTRACT ? 5'b10000 : 5'b00000;
  endfunction
endpackage

// File: rtl/timesync_phase_sequencer_if.sv
// timesync_phase_sequencer_if: shared input-buffer port, engine requests in and BRAM port out
interface timesync_phase_sequencer_if #(parameter int ADDR_W = 12, parameter int DATA_W = 8);
  import timesync_pkg::*;
  logic [NREQ-1:0]        req_en;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_din;
  logic                   buf_en;
  logic                   buf_we;
  logic [ADDR_W-1:0]      buf_addr;
  logic [DATA_W-1:0]      buf_din;
  modport master (output req_en, req_we, req_addr, req_din, input buf_en, buf_we, buf_addr, buf_din);
  modport slave (input req_en, req_we, req_addr, req_din, output buf_en, buf_we, buf_addr, buf_din);
endinterface

// File: rtl/timesync_buf_port_mux.sv
// timesync_buf_port_mux: grants the buffer port to the current owner only, one register stage
module timesync_buf_port_mux
  import timesync_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  i_owner,
  input  logic                        i_owner_vld,
  timesync_phase_sequencer_if.slave   bus,
  output logic                        o_conflict
);
  logic [NREQ-1:0] w_mask;
  logic            w_gnt;
  assign w_mask     = i_owner_vld ? NREQ'(1) << i_owner : '0;
  assign w_gnt      = |(bus.req_en & w_mask);
  assign o_conflict = |(bus.req_en & ~w_mask);
  // address/data hold while idle so the BRAM sees no spurious toggling
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.buf_en   <= 1'b0;
      bus.buf_we   <= 1'b0;
      bus.buf_addr <= '0;
      bus.buf_din  <= '0;
    end else begin
      bus.buf_en <= w_gnt;
      bus.buf_we <= w_gnt & bus.req_we[i_owner];
      if (w_gnt) begin
        bus.buf_addr <= bus.req_addr[i_owner*ADDR_W +: ADDR_W];
        bus.buf_din  <= bus.req_din[i_owner*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: rtl/timesync_phase_sequencer.sv
// timesync_phase_sequencer: steps the sync burst through its phases and arbitrates the input buffer
module timesync_phase_sequencer
  import timesync_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_done,
  input  logic                      in_full,
  output logic                      start_p,
  output logic                      start_r,
  output logic                      start_m,
  output logic                      start_det,
  output logic                      start_ext,
  input  logic                      done_p,
  input  logic                      done_r,
  input  logic                      done_m,
  input  logic                      done_det,
  input  logic                      done_ext,
  timesync_phase_sequencer_if.slave bus,
  output logic [3:0]                phase,
  output logic                      out_ready,
  output logic                      err_conflict,
  output logic                      err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_start, w_start;
  logic            r_ready, r_econf, r_eto;
  logic            w_active, w_exit, w_to, w_conflict, w_owner_vld;
  logic [1:0]      w_owner;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_start <= '0;
      r_ready <= 1'b0;
      r_econf <= 1'b0;
      r_eto   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || !w_active) ? '0 : r_cnt + 1'b1;
      r_start <= w_start;
      r_ready <= w_next == S_READY;
      r_econf <= r_econf | w_conflict;
      r_eto   <= r_eto | w_to;
    end
  end
  // restart beats completion and timeout; completion beats timeout
  always_comb begin
    w_active = r_state >= S_CAPTURE && r_state <= S_EXTRACT;
    w_exit   = r_state == S_CAPTURE ? in_full :
               r_state == S_CALC_P  ? done_p :
               r_state == S_CALC_R  ? done_r :
               r_state == S_CALC_M  ? done_m :
               r_state == S_DETECT  ? done_det :
               r_state == S_EXTRACT ? done_ext : 1'b0;
    w_to     = w_active && !w_exit && !tx_done && r_cnt == CW'(TIMEOUT - 1);
    w_next   = r_state == S_IDLE ? S_CAPTURE :
               tx_done           ? S_IDLE :
               w_exit            ? state_t'(r_state + 4'd1) :
               w_to              ? S_HALT : r_state;
  end
  always_comb begin
    w_start     = (w_next != r_state) ? start_mask(w_next) : 5'b0;
    w_owner_vld = r_state == S_CAPTURE || r_state == S_CALC_P || r_state == S_CALC_R || r_state == S_EXTRACT;
    w_owner     = r_state == S_CALC_P  ? REQ_P :
                  r_state == S_CALC_R  ? REQ_R :
                  r_state == S_EXTRACT ? REQ_EXT : REQ_CAP;
  end
  timesync_buf_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .clk        (clk),
    .rst        (rst),
    .i_owner    (w_owner),
    .i_owner_vld(w_owner_vld),
    .bus        (bus),
    .o_conflict (w_conflict)
  );
  assign {start_ext, start_det, start_m, start_r, start_p} = r_start;
  assign phase        = r_state;
  assign out_ready    = r_ready;
  assign err_conflict = r_econf;
  assign err_timeout  = r_eto;
endmodule
